fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited instruction memory requests, in-order PC tagging of
// responses and a small instruction buffer toward decode; flush redirects and drops stale data.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
);

  localparam int unsigned     PtrW     = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]      DepthCnt = 3'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]     fpc_q, fpc_d;
  logic [2:0]      out_q, out_d;
  logic [2:0]      drop_q, drop_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PtrW-1:0] frd_q, frd_d, fwr_q, fwr_d;
  logic [PtrW-1:0] qrd_q, qrd_d, qwr_q, qwr_d;

  logic [31:0] pcq_mem   [FIFO_DEPTH];
  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0] fifo_inst [FIFO_DEPTH];

  logic [2:0] credit;
  logic       accept, keep_rsp, push, pop, fifo_nonempty;

  // Outstanding requests plus buffered words never exceed the buffer size, so pushes always fit.
  assign credit        = out_q + cnt_q;
  assign o_imem_req    = rst_n & ~i_flush & (credit < DepthCnt);
  assign o_imem_addr   = fpc_q;
  assign accept        = o_imem_req & i_imem_gnt;
  assign keep_rsp      = i_imem_rvalid & (drop_q == 3'd0);
  assign push          = ~i_flush & keep_rsp;
  assign fifo_nonempty = (cnt_q != 3'd0);
  assign o_if_valid    = fifo_nonempty & ~i_flush;
  assign pop           = o_if_valid & ~i_stall;
  assign o_if_pc       = fifo_nonempty ? fifo_pc[frd_q] : 32'h0;
  assign o_if_instr    = fifo_nonempty ? fifo_inst[frd_q] : 32'h0;

  always_comb begin
    fpc_d  = fpc_q;
    out_d  = out_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    frd_d  = frd_q;
    fwr_d  = fwr_q;
    qrd_d  = qrd_q;
    qwr_d  = qwr_q;
    if (i_flush) begin
      // Every response still owed by memory belongs to the discarded path.
      fpc_d  = {i_redirect_pc[31:2], 2'b00};
      out_d  = out_q - {2'b00, i_imem_rvalid};
      drop_d = out_q - {2'b00, i_imem_rvalid};
      cnt_d  = '0;
      frd_d  = '0;
      fwr_d  = '0;
      qrd_d  = '0;
      qwr_d  = '0;
    end else begin
      if (accept) begin
        fpc_d = fpc_q + 32'd4;
        qwr_d = ptr_inc(qwr_q);
      end
      out_d = out_q + {2'b00, accept} - {2'b00, i_imem_rvalid};
      if (i_imem_rvalid && (drop_q != 3'd0)) begin
        drop_d = drop_q - 3'd1;
      end
      if (push) begin
        fwr_d = ptr_inc(fwr_q);
        qrd_d = ptr_inc(qrd_q);
      end
      if (pop) begin
        frd_d = ptr_inc(frd_q);
      end
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q  <= {RESET_PC[31:2], 2'b00};
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      frd_q  <= '0;
      fwr_q  <= '0;
      qrd_q  <= '0;
      qwr_q  <= '0;
    end else begin
      fpc_q  <= fpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      frd_q  <= frd_d;
      fwr_q  <= fwr_d;
      qrd_q  <= qrd_d;
      qwr_q  <= qwr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq_mem[qwr_q] <= fpc_q;
    end
    if (push) begin
      fifo_pc[fwr_q]   <= pcq_mem[qrd_q];
      fifo_inst[fwr_q] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic scored
// against a queue-based model of in-flight requests and buffered instructions.
module tb_fetch_stage;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall, i_flush, i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_req, o_if_valid;
  logic [31:0] o_imem_addr, o_if_pc, o_if_instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_if_valid   (o_if_valid),
    .o_if_pc      (o_if_pc),
    .o_if_instr   (o_if_instr)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } fl_t;

  fl_t         infl[$];      // model: accepted requests awaiting a response
  logic [31:0] bufq[$];      // model: PCs buffered for decode
  logic [31:0] mem_pend[$];  // memory: granted addresses still to be answered
  logic [31:0] exp_pc;
  bit          nop_mode;
  int          n_checks, n_pass;

  logic        s_req, s_valid, e_req, e_valid;
  logic [31:0] s_addr, s_pc, s_instr, e_addr, e_pc, e_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  task automatic clear_model();
    infl.delete();
    bufq.delete();
    mem_pend.delete();
    exp_pc = {ResetPc[31:2], 2'b00};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_stall = 1'b0; i_flush = 1'b0; i_redirect_pc = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: drive inputs, sample outputs at the falling edge, advance memory and model.
  task automatic step(input bit stall, input bit flush, input logic [31:0] rpc, input bit gnt,
                      input bit rv_en);
    bit  rv;
    fl_t f;
    i_stall       = stall;
    i_flush       = flush;
    i_redirect_pc = rpc;
    i_imem_gnt    = gnt;
    rv            = rv_en && (mem_pend.size() > 0);
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? instr_of(mem_pend[0]) : $urandom;
    @(negedge clk);
    s_req   = o_imem_req;
    s_addr  = o_imem_addr;
    s_valid = o_if_valid;
    s_pc    = o_if_pc;
    s_instr = o_if_instr;
    e_req   = !flush && ((infl.size() + bufq.size()) < Depth);
    e_addr  = exp_pc;
    e_valid = (bufq.size() > 0) && !flush;
    e_pc    = (bufq.size() > 0) ? bufq[0] : 32'h0;
    e_instr = (bufq.size() > 0) ? instr_of(bufq[0]) : 32'h0;
    if (rv) void'(mem_pend.pop_front());
    if (o_imem_req && gnt) mem_pend.push_back(o_imem_addr);
    if (flush) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      if (rv && infl.size() > 0) void'(infl.pop_front());
      bufq.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && !stall) void'(bufq.pop_front());
      if (rv && infl.size() > 0) begin
        f = infl.pop_front();
        if (!f.stale) bufq.push_back(f.addr);
      end
      if (e_req && gnt) begin
        f.addr  = exp_pc;
        f.stale = 1'b0;
        infl.push_back(f);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_stall = 1'b0; i_flush = 1'b0; i_redirect_pc = 32'h40;
    i_imem_gnt = 1'b1; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_imem_req !== 1'b0) $display("FAIL reset_req got=%0b want=0", o_imem_req);
    else n_pass++;
    n_checks++;
    if (o_if_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", o_if_valid);
    else n_pass++;
    n_checks++;
    if (o_if_pc !== 32'h0) $display("FAIL reset_pc got=%h want=0", o_if_pc);
    else n_pass++;
    n_checks++;
    if (o_if_instr !== 32'h0) $display("FAIL reset_instr got=%h want=0", o_if_instr);
    else n_pass++;
    n_checks++;
    if (o_imem_addr !== ResetPc) $display("FAIL reset_addr got=%h want=%h", o_imem_addr, ResetPc);
    else n_pass++;
    @(posedge clk);
    #1;
    i_imem_rvalid = 1'b0; i_imem_gnt = 1'b0; i_redirect_pc = '0;
    rst_n = 1'b1;
    clear_model();
    step(0, 0, 32'h0, 0, 0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== ResetPc)
      $display("FAIL post_reset_req got=%0b/%h want=1/%h", s_req, s_addr, ResetPc);
    else n_pass++;
    n_checks++;
    if (s_valid !== 1'b0) $display("FAIL post_reset_valid got=%0b want=0", s_valid);
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic [31:0] want;
    int          got;
    apply_reset();
    nop_mode = 1'b1;
    want = 32'h0;
    got  = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      step(0, 0, 32'h0, 1, 1);
      n_checks++;
      if (s_valid !== e_valid) $display("FAIL stream_valid cyc=%0d got=%0b want=%0b", c, s_valid,
                                        e_valid);
      else n_pass++;
      if (s_valid) begin
        n_checks++;
        if (s_pc !== want || s_instr !== 32'h13)
          $display("FAIL stream_word got=%h/%h want=%h/00000013", s_pc, s_instr, want);
        else n_pass++;
        want = want + 32'd4;
        got++;
      end
    end
    n_checks++;
    if (got != 3) $display("FAIL stream_count got=%0d want=3", got);
    else n_pass++;
    nop_mode = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] want;
    int          got;
    apply_reset();
    repeat (4) step(0, 0, 32'h0, 1, 1);
    for (int c = 0; c < 5; c++) begin
      step(1, 0, 32'h0, 1, 1);
      n_checks++;
      if (s_valid !== e_valid || s_pc !== e_pc || s_req !== e_req)
        $display("FAIL stall_hold cyc=%0d got=%0b/%h/%0b want=%0b/%h/%0b", c, s_valid, s_pc,
                 s_req, e_valid, e_pc, e_req);
      else n_pass++;
    end
    n_checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1)
      $display("FAIL stall_full got=req%0b/valid%0b want=req0/valid1", s_req, s_valid);
    else n_pass++;
    want = e_pc;
    got  = 0;
    for (int c = 0; c < 15; c++) begin
      step(0, 0, 32'h0, 1, 1);
      if (s_valid) begin
        n_checks++;
        if (s_pc !== want || s_instr !== instr_of(want))
          $display("FAIL stall_resume got=%h/%h want=%h/%h", s_pc, s_instr, want, instr_of(want));
        else n_pass++;
        want = want + 32'd4;
        got++;
      end
    end
    n_checks++;
    if (got < 4) $display("FAIL stall_resume_count got=%0d want>=4", got);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen_req, seen_valid;
    apply_reset();
    step(0, 0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 1, 0);
    step(0, 1, 32'h100, 1, 0);
    n_checks++;
    if (s_req !== 1'b0) $display("FAIL flush_req got=%0b want=0", s_req);
    else n_pass++;
    seen_req = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 12 && !seen_valid; c++) begin
      step(0, 0, 32'h0, 1, 1);
      if (s_req && !seen_req) begin
        seen_req = 1'b1;
        n_checks++;
        if (s_addr !== 32'h100) $display("FAIL flush_first_addr got=%h want=00000100", s_addr);
        else n_pass++;
      end
      if (s_valid) begin
        seen_valid = 1'b1;
        n_checks++;
        if (s_pc !== 32'h100 || s_instr !== instr_of(32'h100))
          $display("FAIL flush_first_word got=%h/%h want=00000100/%h", s_pc, s_instr,
                   instr_of(32'h100));
        else n_pass++;
      end
    end
    n_checks++;
    if (!seen_valid) $display("FAIL flush_timeout got=no_valid want=valid");
    else n_pass++;
  endtask

  task automatic test_misaligned();
    apply_reset();
    step(0, 1, 32'h103, 0, 0);
    n_checks++;
    if (s_req !== 1'b0) $display("FAIL misalign_flush_req got=%0b want=0", s_req);
    else n_pass++;
    step(0, 0, 32'h0, 0, 0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100)
      $display("FAIL misalign_addr got=%0b/%h want=1/00000100", s_req, s_addr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 32'h0, 1, 0);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_top got=%0b/%h want=1/fffffffc", s_req, s_addr);
    else n_pass++;
    step(0, 0, 32'h0, 0, 0);
    n_checks++;
    if (s_addr !== 32'h0) $display("FAIL wrap_zero got=%h want=00000000", s_addr);
    else n_pass++;
  endtask

  task automatic test_gnt_hold();
    int c;
    apply_reset();
    c = 0;
    while (exp_pc != 32'h8 && c < 20) begin
      step(0, 0, 32'h0, 1, 1);
      c++;
    end
    c = 0;
    s_req = 1'b0;
    while (!s_req && c < 10) begin
      step(0, 0, 32'h0, 0, 1);
      c++;
    end
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h8)
      $display("FAIL gnt_first got=%0b/%h want=1/00000008", s_req, s_addr);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 32'h0, 0, 1);
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h8)
        $display("FAIL gnt_hold k=%0d got=%0b/%h want=1/00000008", k, s_req, s_addr);
      else n_pass++;
    end
    step(0, 0, 32'h0, 1, 1);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h8)
      $display("FAIL gnt_accept got=%0b/%h want=1/00000008", s_req, s_addr);
    else n_pass++;
    step(0, 0, 32'h0, 0, 1);
    n_checks++;
    if (s_addr !== 32'hC) $display("FAIL gnt_next got=%h want=0000000c", s_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          st, fl, gn, rv;
    logic [31:0] rpc;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      st  = $urandom_range(0, 99) < 30;
      fl  = $urandom_range(0, 99) < 5;
      gn  = $urandom_range(0, 99) < 70;
      rv  = $urandom_range(0, 99) < 75;
      rpc = $urandom;
      step(st, fl, rpc, gn, rv);
      n_checks++;
      if (s_req !== e_req) $display("FAIL rnd_req cyc=%0d got=%0b want=%0b", c, s_req, e_req);
      else n_pass++;
      n_checks++;
      if (s_addr !== e_addr) $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, s_addr, e_addr);
      else n_pass++;
      n_checks++;
      if (s_valid !== e_valid)
        $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, s_valid, e_valid);
      else n_pass++;
      n_checks++;
      if (s_pc !== e_pc) $display("FAIL rnd_pc cyc=%0d got=%h want=%h", c, s_pc, e_pc);
      else n_pass++;
      n_checks++;
      if (s_instr !== e_instr)
        $display("FAIL rnd_instr cyc=%0d got=%h want=%h", c, s_instr, e_instr);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    nop_mode = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_gnt_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
